pc_sequencer: RTL and testbench

Fetch/execute sequencer that owns the 8-bit program counter of the processor datapath and sequences its updates. It issues one fetch request per instruction to instruction memory, with a valid/ready handshake, and holds the PC through a fixed-length execute phase. At the end of execute it advances the PC, either incrementing with wrap-around or loading a jump target. It sits between the control unit (start/halt/jump) and the instruction memory address port.

---
 rtl/pc_sequencer_if.sv | 21 ++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port: PC address plus valid/ready handshake.
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic [PC_W-1:0] pcc;
  logic            fetch_valid;
  logic            imem_ready;

  // Sequencer side drives the address and request, memory answers with ready
  modport master (
    output pcc,
    output fetch_valid,
    input  imem_ready
  );

  modport slave (
    input  pcc,
    input  fetch_valid,
    output imem_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the program counter and retire counter.
module pc_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned LAST_ADDR   = 255,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt_req,
  input  logic                jump_valid,
  input  logic [PC_W-1:0]     jump_addr,
  pc_sequencer_if.master      imem,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         instr_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ICNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pcc_q, pcc_d;
  logic [CNT_W-1:0]    exec_cnt_q, exec_cnt_d;
  logic                halt_latch_q, halt_latch_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic [ICNT_W-1:0]   instr_count_q, instr_count_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pcc_q         <= '0;
      exec_cnt_q    <= '0;
      halt_latch_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pcc_q         <= pcc_d;
      exec_cnt_q    <= exec_cnt_d;
      halt_latch_q  <= halt_latch_d;
      fetch_valid_q <= fetch_valid_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state, PC update and flag decode; flags follow the next state
  always_comb begin
    state_d       = state_q;
    pcc_d         = pcc_q;
    exec_cnt_d    = exec_cnt_q;
    halt_latch_d  = halt_latch_q;
    instr_count_d = instr_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (halt_req) halt_latch_d = 1'b1;
        if (imem.imem_ready) begin
          state_d    = ST_EXEC;
          exec_cnt_d = CNT_W'(EXEC_CYCLES - 1);
        end
      end
      ST_EXEC: begin
        if (halt_req) halt_latch_d = 1'b1;
        if (exec_cnt_q == '0) begin
          // Last execute cycle: retire and advance the PC
          if (jump_valid) begin
            pcc_d = jump_addr;
          end else if (pcc_q == PC_W'(LAST_ADDR)) begin
            pcc_d = '0;
          end else begin
            pcc_d = pcc_q + PC_W'(1);
          end
          if (instr_count_q != {ICNT_W{1'b1}}) begin
            instr_count_d = instr_count_q + ICNT_W'(1);
          end
          if (halt_latch_q || halt_req) begin
            state_d      = ST_HALT;
            halt_latch_d = 1'b0;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          exec_cnt_d = exec_cnt_q - CNT_W'(1);
        end
      end
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    fetch_valid_d = (state_d == ST_FETCH);
    busy_d        = (state_d == ST_FETCH) || (state_d == ST_EXEC);
    halted_d      = (state_d == ST_HALT);
  end

  assign imem.pcc         = pcc_q;
  assign imem.fetch_valid = fetch_valid_q;
  assign busy             = busy_q;
  assign halted           = halted_q;
  assign instr_count      = instr_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: table-driven wrap/back-pressure run plus hand sequences.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  // Instance A: LAST_ADDR=3, EXEC_CYCLES=1
  logic       a_start, a_halt_req, a_jump_valid;
  logic [7:0] a_jump_addr;
  logic       a_busy, a_halted;
  logic [15:0] a_instr_count;
  pc_sequencer_if #(.PC_W(8)) if_a ();

  // Instance B: LAST_ADDR=255, EXEC_CYCLES=3
  logic       b_start, b_halt_req, b_jump_valid;
  logic [7:0] b_jump_addr;
  logic       b_busy, b_halted;
  logic [15:0] b_instr_count;
  pc_sequencer_if #(.PC_W(8)) if_b ();

  pc_sequencer #(.PC_W(8), .LAST_ADDR(3), .EXEC_CYCLES(1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (a_start),
    .halt_req    (a_halt_req),
    .jump_valid  (a_jump_valid),
    .jump_addr   (a_jump_addr),
    .imem        (if_a.master),
    .busy        (a_busy),
    .halted      (a_halted),
    .instr_count (a_instr_count)
  );

  pc_sequencer #(.PC_W(8), .LAST_ADDR(255), .EXEC_CYCLES(3)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (b_start),
    .halt_req    (b_halt_req),
    .jump_valid  (b_jump_valid),
    .jump_addr   (b_jump_addr),
    .imem        (if_b.master),
    .busy        (b_busy),
    .halted      (b_halted),
    .instr_count (b_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic        ready;
    logic [7:0]  exp_pcc;
    logic        exp_fv;
    logic        exp_busy;
    logic        exp_halted;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic [7:0] pcc, input logic fv,
                       input logic bsy, input logic hlt, input logic [15:0] cnt);
    chk({name, ".pcc"},    32'(if_b.pcc),         32'(pcc));
    chk({name, ".fv"},     32'(if_b.fetch_valid), 32'(fv));
    chk({name, ".busy"},   32'(b_busy),           32'(bsy));
    chk({name, ".halted"}, 32'(b_halted),         32'(hlt));
    chk({name, ".cnt"},    32'(b_instr_count),    32'(cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [7:0] p,
                              input logic fv, input logic [15:0] c);
    vec_t v;
    v.start = s; v.ready = r; v.exp_pcc = p; v.exp_fv = fv;
    v.exp_busy = 1'b1; v.exp_halted = 1'b0; v.exp_cnt = c;
    return v;
  endfunction

  initial begin
    // Wrap through 0..3, then 5 cycles of back-pressure at pcc=2
    vecs[0]  = mk(1, 1, 8'd0, 1, 16'd0);
    vecs[1]  = mk(1, 1, 8'd0, 0, 16'd0);
    vecs[2]  = mk(1, 1, 8'd1, 1, 16'd1);
    vecs[3]  = mk(1, 1, 8'd1, 0, 16'd1);
    vecs[4]  = mk(1, 1, 8'd2, 1, 16'd2);
    vecs[5]  = mk(1, 1, 8'd2, 0, 16'd2);
    vecs[6]  = mk(1, 1, 8'd3, 1, 16'd3);
    vecs[7]  = mk(1, 1, 8'd3, 0, 16'd3);
    vecs[8]  = mk(1, 1, 8'd0, 1, 16'd4);
    vecs[9]  = mk(1, 1, 8'd0, 0, 16'd4);
    vecs[10] = mk(1, 1, 8'd1, 1, 16'd5);
    vecs[11] = mk(1, 1, 8'd1, 0, 16'd5);
    vecs[12] = mk(1, 1, 8'd2, 1, 16'd6);
    vecs[13] = mk(1, 0, 8'd2, 1, 16'd6);
    vecs[14] = mk(1, 0, 8'd2, 1, 16'd6);
    vecs[15] = mk(1, 0, 8'd2, 1, 16'd6);
    vecs[16] = mk(1, 0, 8'd2, 1, 16'd6);
    vecs[17] = mk(1, 0, 8'd2, 1, 16'd6);
    vecs[18] = mk(1, 1, 8'd2, 0, 16'd6);
    vecs[19] = mk(1, 1, 8'd3, 1, 16'd7);

    rst_n = 1'b0;
    a_start = 0; a_halt_req = 0; a_jump_valid = 0; a_jump_addr = '0; if_a.imem_ready = 0;
    b_start = 0; b_halt_req = 0; b_jump_valid = 0; b_jump_addr = '0; if_b.imem_ready = 0;
    #22;
    chk("rst_a.pcc",  32'(if_a.pcc), 32'd0);
    chk("rst_a.fv",   32'(if_a.fetch_valid), 32'd0);
    chk_b("rst_b", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven run on instance A
    for (int i = 0; i < 20; i++) begin
      a_start = vecs[i].start;
      if_a.imem_ready = vecs[i].ready;
      step();
      chk($sformatf("vecA[%0d].pcc", i),    32'(if_a.pcc),         32'(vecs[i].exp_pcc));
      chk($sformatf("vecA[%0d].fv", i),     32'(if_a.fetch_valid), 32'(vecs[i].exp_fv));
      chk($sformatf("vecA[%0d].busy", i),   32'(a_busy),           32'(vecs[i].exp_busy));
      chk($sformatf("vecA[%0d].halted", i), 32'(a_halted),         32'(vecs[i].exp_halted));
      chk($sformatf("vecA[%0d].cnt", i),    32'(a_instr_count),    32'(vecs[i].exp_cnt));
    end
    a_start = 0;

    // Jump taken in the last EXEC cycle
    b_start = 1; if_b.imem_ready = 0;
    step();
    chk_b("b_fetch0", 8'd0, 1, 1, 0, 16'd0);
    b_start = 0; if_b.imem_ready = 1;
    step();
    chk_b("b_exec0", 8'd0, 0, 1, 0, 16'd0);
    step();
    step();
    b_jump_valid = 1; b_jump_addr = 8'hA0;
    step();
    b_jump_valid = 0;
    chk_b("b_jump", 8'hA0, 1, 1, 0, 16'd1);

    // Jump in an early EXEC cycle is ignored
    step();
    b_jump_valid = 1; b_jump_addr = 8'h55;
    step();
    b_jump_valid = 0;
    chk_b("b_earlyjmp_hold", 8'hA0, 0, 1, 0, 16'd1);
    step();
    chk_b("b_earlyjmp_last", 8'hA0, 0, 1, 0, 16'd1);
    step();
    chk_b("b_earlyjmp", 8'hA1, 1, 1, 0, 16'd2);

    // Jump to 5 to set up halt test
    step(); step(); step();
    b_jump_valid = 1; b_jump_addr = 8'd5;
    step();
    b_jump_valid = 0;
    chk_b("b_at5", 8'd5, 1, 1, 0, 16'd3);

    // One-cycle halt pulse in FETCH, instruction still retires
    b_halt_req = 1;
    step();
    b_halt_req = 0;
    chk_b("b_halt_exec", 8'd5, 0, 1, 0, 16'd3);
    step(); step(); step();
    chk_b("b_halted", 8'd6, 0, 0, 1, 16'd4);
    step(); step();
    chk_b("b_halted_hold", 8'd6, 0, 0, 1, 16'd4);
    b_start = 1;
    step();
    b_start = 0;
    chk_b("b_resume", 8'd6, 1, 1, 0, 16'd4);

    // Halt and jump together in the last EXEC cycle
    step(); step(); step();
    b_halt_req = 1; b_jump_valid = 1; b_jump_addr = 8'h10;
    step();
    b_halt_req = 0; b_jump_valid = 0;
    chk_b("b_halt_jump", 8'h10, 0, 0, 1, 16'd5);

    // Reach pcc=7 with count=7: jump to 6, then increment
    b_start = 1;
    step();
    b_start = 0;
    step(); step(); step();
    b_jump_valid = 1; b_jump_addr = 8'd6;
    step();
    b_jump_valid = 0;
    chk_b("b_at6", 8'd6, 1, 1, 0, 16'd6);
    step(); step(); step(); step();
    chk_b("b_at7", 8'd7, 1, 1, 0, 16'd7);
    step(); step();
    chk_b("b_mid_exec", 8'd7, 0, 1, 0, 16'd7);

    // Asynchronous reset mid-EXEC
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("b_async_rst", 8'd0, 0, 0, 0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step(); step();
    chk_b("b_idle_after_rst", 8'd0, 0, 0, 0, 16'd0);
    b_start = 1;
    step();
    b_start = 0;
    chk_b("b_restart", 8'd0, 1, 1, 0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
